wb_arbiter2: RTL and testbench

Two-master, one-slave Wishbone arbiter. It shares a single Wishbone slave port between two requesters, such as the LM32 instruction and data ports in front of a single-ported slave or a second bus master (DMA/SPI loader) beside the CPU. Arbitration is round-robin. A grant is held for the full duration of `cyc`. An optional watchdog terminates stalled cycles with `err`. The block sits between the masters and the bus interconnect and adds no per-beat latency once a grant is given.

---
 rtl/wb_arbiter2_if.sv | 30 +++
 rtl/wb_arbiter2.sv | 133 +++++++++++++
 tb/tb_wb_arbiter2.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter2_if.sv
// Wishbone bundle for the two-master arbiter: both master ports, the slave port and the grant.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wb_arbiter2_if #(
    parameter int adr_width = 32
);
    logic [adr_width-1:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [31:0]          m0_dat_i, m1_dat_i, s_dat_o;
    logic [31:0]          m0_dat_o, m1_dat_o, s_dat_i;
    logic [3:0]           m0_sel_i, m1_sel_i, s_sel_o;
    logic                 m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
    logic                 m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
    logic                 s_we_o, s_cyc_o, s_stb_o, s_ack_i;
    logic [1:0]           gnt_o;

    modport slave (
        input  m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
        input  m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
        input  s_dat_i, s_ack_i,
        output m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, gnt_o
    );

    modport master (
        output m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
        output m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
        output s_dat_i, s_ack_i,
        input  m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, gnt_o
    );
endinterface

// File: rtl/wb_arbiter2.sv
// Round-robin two-master Wishbone arbiter; grant held for the whole cyc.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter2 #(
    parameter int adr_width      = 32,
    parameter int timeout_cycles = 255
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter2_if.slave bus
);

    if (timeout_cycles < 1 || timeout_cycles > 65535) begin : g_bad_timeout
        $error("timeout_cycles must lie in 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1
`ifdef WB_ARB_TIMEOUT_EN
        , ERR
`endif
    } state_t;

    state_t               state;
    logic                 last;       // 0 = m0 granted most recently, 1 = m1
    logic [1:0]           gnt;
    logic [adr_width-1:0] adr_mux;
    logic                 stb_mux;
    logic                 granted_cyc;

    // While in GNTx, last names the granted master.
    assign granted_cyc = last ? bus.m1_cyc_i : bus.m0_cyc_i;

    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        adr_mux       = bus.m0_adr_i;
        bus.s_dat_o   = bus.m0_dat_i;
        bus.s_sel_o   = bus.m0_sel_i;
        bus.s_we_o    = 1'b0;
        bus.s_cyc_o   = 1'b0;
        stb_mux       = 1'b0;
        bus.m0_ack_o  = 1'b0;
        bus.m1_ack_o  = 1'b0;
        if (gnt[0]) begin
            bus.s_we_o   = bus.m0_we_i;
            bus.s_cyc_o  = bus.m0_cyc_i;
            stb_mux      = bus.m0_stb_i;
            bus.m0_ack_o = bus.s_ack_i;
        end else if (gnt[1]) begin
            adr_mux      = bus.m1_adr_i;
            bus.s_dat_o  = bus.m1_dat_i;
            bus.s_sel_o  = bus.m1_sel_i;
            bus.s_we_o   = bus.m1_we_i;
            bus.s_cyc_o  = bus.m1_cyc_i;
            stb_mux      = bus.m1_stb_i;
            bus.m1_ack_o = bus.s_ack_i;
        end
    end

    assign bus.s_adr_o  = adr_mux;
    assign bus.s_stb_o  = stb_mux;
    assign bus.m0_dat_o = bus.s_dat_i;
    assign bus.m1_dat_o = bus.s_dat_i;
    assign bus.gnt_o    = gnt;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] wdog_limit = 16'(timeout_cycles - 1);
    logic [15:0] wdog;
    logic        stalled;

    assign stalled      = stb_mux && !bus.s_ack_i;
    assign bus.m0_err_o = (state == ERR) && !last;
    assign bus.m1_err_o = (state == ERR) && last;

    // Holding at zero through IDLE gives the clear on entry to GNTx.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wdog <= 16'd0;
        end else if (state == IDLE || bus.s_ack_i) begin
            wdog <= 16'd0;
        end else if (stalled) begin
            wdog <= wdog + 16'd1;
        end
    end
`else
    assign bus.m0_err_o = 1'b0;
    assign bus.m1_err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state <= IDLE;
            last  <= 1'b1;
            gnt   <= 2'b00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.m0_cyc_i && (!bus.m1_cyc_i || last)) begin
                        state <= GNT0;
                        last  <= 1'b0;
                        gnt   <= 2'b01;
                    end else if (bus.m1_cyc_i) begin
                        state <= GNT1;
                        last  <= 1'b1;
                        gnt   <= 2'b10;
                    end
                end
                GNT0, GNT1: begin
                    if (!granted_cyc) begin
                        state <= IDLE;
                        gnt   <= 2'b00;
                    end
`ifdef WB_ARB_TIMEOUT_EN
                    else if (stalled && wdog == wdog_limit) begin
                        state <= ERR;
                        gnt   <= 2'b00;
                    end
`endif
                end
`ifdef WB_ARB_TIMEOUT_EN
                ERR: state <= IDLE;
`endif
                default: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed self-checking bench for wb_arbiter2: reset, single master, contention,
// grant hold, watchdog (either build) and mid-cycle reset.
module tb_wb_arbiter2;
`ifdef WB_ARB_TIMEOUT_EN
    localparam int tmo = 4;
`else
    localparam int tmo = 255;
`endif

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    wb_arbiter2_if #(.adr_width(32)) bus ();

    wb_arbiter2 #(.adr_width(32), .timeout_cycles(tmo)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        #0;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive_m(input int who, input logic en, input logic [31:0] adr);
        if (who == 0) begin
            bus.m0_cyc_i = en; bus.m0_stb_i = en; bus.m0_adr_i = adr;
        end else begin
            bus.m1_cyc_i = en; bus.m1_stb_i = en; bus.m1_adr_i = adr;
        end
    endtask

    task automatic clear_inputs();
        bus.m0_adr_i = '0; bus.m0_dat_i = '0; bus.m0_sel_i = '0;
        bus.m0_we_i = 0; bus.m0_cyc_i = 0; bus.m0_stb_i = 0;
        bus.m1_adr_i = '0; bus.m1_dat_i = '0; bus.m1_sel_i = '0;
        bus.m1_we_i = 0; bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
        bus.s_dat_i = '0; bus.s_ack_i = 0;
    endtask

    // Ack the granted master once, drop its cyc for one cycle (IDLE gap), then re-raise it.
    task automatic serve(input int who, input logic [31:0] adr);
        bus.s_ack_i = 1'b1;
        #1;
        check($sformatf("serve%0d own ack", who), who == 0 ? bus.m0_ack_o : bus.m1_ack_o, 1);
        check($sformatf("serve%0d other ack", who), who == 0 ? bus.m1_ack_o : bus.m0_ack_o, 0);
        tick();
        bus.s_ack_i = 1'b0;
        drive_m(who, 1'b0, adr);
        tick();
        check($sformatf("serve%0d idle gap", who), bus.gnt_o, 2'b00);
        drive_m(who, 1'b1, adr);
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        tick();
        tick();
        check("rst gnt", bus.gnt_o, 2'b00);
        check("rst s_cyc", bus.s_cyc_o, 0);
        check("rst s_stb", bus.s_stb_o, 0);
        check("rst acks", {bus.m0_ack_o, bus.m1_ack_o}, 2'b00);
        check("rst errs", {bus.m0_err_o, bus.m1_err_o}, 2'b00);
        rst = 1'b1;
        tick();

        // Single master read, slave acks on the 2nd strobe cycle.
        drive_m(0, 1'b1, 32'h2000_0004);
        bus.m0_sel_i = 4'hF;
        #1;
        check("single pre gnt", bus.gnt_o, 2'b00);
        check("single pre s_cyc", bus.s_cyc_o, 0);
        tick();
        check("single gnt", bus.gnt_o, 2'b01);
        check("single s_stb", bus.s_stb_o, 1);
        check("single s_adr", bus.s_adr_o, 32'h2000_0004);
        check("single ack beat1", bus.m0_ack_o, 0);
        tick();
        bus.s_ack_i = 1'b1;
        bus.s_dat_i = 32'hDEAD_BEEF;
        #1;
        check("single ack", bus.m0_ack_o, 1);
        check("single dat", bus.m0_dat_o, 32'hDEAD_BEEF);
        check("single m1 ack", bus.m1_ack_o, 0);
        tick();
        bus.s_ack_i = 1'b0;
        drive_m(0, 1'b0, 32'h2000_0004);
        #1;
        check("single s_cyc drop", bus.s_cyc_o, 0);
        tick();
        check("single back idle", bus.gnt_o, 2'b00);

        // Fresh reset, then continuous contention: m0, m1, m0, m1.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        drive_m(0, 1'b1, 32'h0000_1000);
        drive_m(1, 1'b1, 32'h0000_2000);
        tick();
        check("cont grant1", bus.gnt_o, 2'b01);
        check("cont adr1", bus.s_adr_o, 32'h0000_1000);
        serve(0, 32'h0000_1000);
        tick();
        check("cont grant2", bus.gnt_o, 2'b10);
        check("cont adr2", bus.s_adr_o, 32'h0000_2000);
        serve(1, 32'h0000_2000);
        tick();
        check("cont grant3", bus.gnt_o, 2'b01);
        serve(0, 32'h0000_1000);
        tick();
        check("cont grant4", bus.gnt_o, 2'b10);
        bus.s_ack_i = 1'b1;
        tick();
        bus.s_ack_i = 1'b0;
        drive_m(0, 1'b0, 32'h0);
        drive_m(1, 1'b0, 32'h0);
        tick();
        check("cont end idle", bus.gnt_o, 2'b00);

        // Grant hold: m1 4-beat cycle, m0 requests at beat 2.
        drive_m(1, 1'b1, 32'h0000_3000);
        tick();
        for (int beat = 1; beat <= 4; beat++) begin
            if (beat == 2) drive_m(0, 1'b1, 32'h0000_4000);
            bus.s_ack_i = 1'b1;
            #1;
            check($sformatf("hold gnt b%0d", beat), bus.gnt_o, 2'b10);
            check($sformatf("hold m1 ack b%0d", beat), bus.m1_ack_o, 1);
            check($sformatf("hold m0 ack b%0d", beat), bus.m0_ack_o, 0);
            tick();
        end
        bus.s_ack_i = 1'b0;
        drive_m(1, 1'b0, 32'h0);
        tick();
        check("hold idle", bus.gnt_o, 2'b00);
        tick();
        check("hold m0 granted", bus.gnt_o, 2'b01);
        bus.s_ack_i = 1'b1;
        #1;
        check("hold m0 ack", bus.m0_ack_o, 1);
        tick();
        bus.s_ack_i = 1'b0;
        drive_m(0, 1'b0, 32'h0);
        tick();

        // Watchdog: slave never acks.
        drive_m(0, 1'b1, 32'h0000_5000);
        tick();
`ifdef WB_ARB_TIMEOUT_EN
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("wd stall stb c%0d", c), bus.s_stb_o, 1);
            check($sformatf("wd stall err c%0d", c), bus.m0_err_o, 0);
            tick();
        end
        check("wd err", bus.m0_err_o, 1);
        check("wd err m1", bus.m1_err_o, 0);
        check("wd err s_cyc", bus.s_cyc_o, 0);
        check("wd err gnt", bus.gnt_o, 2'b00);
        tick();
        check("wd err one cycle", bus.m0_err_o, 0);
        check("wd idle gnt", bus.gnt_o, 2'b00);
        tick();
        check("wd regrant", bus.gnt_o, 2'b01);
        tick();
        tick();
        tick();
        bus.s_ack_i = 1'b1;
        tick();
        bus.s_ack_i = 1'b0;
        check("wd ack wins err", bus.m0_err_o, 0);
        check("wd ack wins gnt", bus.gnt_o, 2'b01);
`else
        for (int c = 1; c <= 20; c++) begin
            if (c % 5 == 0) begin
                check($sformatf("nowd stb c%0d", c), bus.s_stb_o, 1);
                check($sformatf("nowd err c%0d", c), bus.m0_err_o, 0);
            end
            tick();
        end
        check("nowd gnt held", bus.gnt_o, 2'b01);
`endif
        drive_m(0, 1'b0, 32'h0);
        tick();
        tick();

        // Reset asserted for one cycle during GNT1.
        drive_m(1, 1'b1, 32'h0000_6000);
        bus.m1_we_i = 1'b1;
        tick();
        check("mid gnt1", bus.gnt_o, 2'b10);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        clear_inputs();
        #1;
        check("mid gnt", bus.gnt_o, 2'b00);
        check("mid s_cyc", bus.s_cyc_o, 0);
        check("mid s_stb", bus.s_stb_o, 0);
        check("mid s_we", bus.s_we_o, 0);
        check("mid s_adr", bus.s_adr_o, 32'h0);
        check("mid acks errs", {bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o}, 4'h0);
        drive_m(0, 1'b1, 32'h0000_7000);
        drive_m(1, 1'b1, 32'h0000_8000);
        tick();
        check("mid next contention", bus.gnt_o, 2'b01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
